systolic_hadamard_npt: RTL and testbench

- Parametrised N-point (N = 2^LOG2N) linear systolic Walsh-Hadamard transform; successor to the fixed 4-point, 9-bit unit.
- Accepts one frame of N signed samples per valid/ready handshake and emits the N transform coefficients serially, one per cycle, through an N-1 stage add/subtract chain.
- Adds output backpressure, back-to-back frames with no bubbles, selectable natural or sequency order, and frame markers.
- Sits between the sample framer and the coefficient quantiser.

---
 rtl/systolic_hadamard_npt.sv | 124 ++++++++++++
 tb/tb_systolic_hadamard_npt.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_hadamard_npt.sv
// N-point linear systolic Walsh-Hadamard transform: one frame in per handshake,
// N coefficients out serially through an N-1 stage add/subtract chain.
module systolic_hadamard_npt #(
  parameter int LOG2N = 2,
  parameter int DW    = 9,
  parameter int ORDER = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [(1<<LOG2N)*DW-1:0]    x_flat,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DW+LOG2N-1:0]         out_data,
  output logic [LOG2N-1:0]            out_index,
  output logic                        out_last
);
  localparam int N  = 1 << LOG2N;
  localparam int OW = DW + LOG2N;

  typedef logic [LOG2N-1:0] row_t;
  localparam row_t LAST_ROW = row_t'(N - 1);

  // Sequency order: row r selects Hadamard row bitreverse(gray(r)).
  function automatic row_t row_to_k(input row_t r);
    row_t g;
    row_t k;
    g = r ^ (r >> 1);
    for (int b = 0; b < LOG2N; b++) k[b] = g[LOG2N-1-b];
    return (ORDER == 1) ? k : r;
  endfunction

  logic          w_adv;
  logic          w_accept;
  logic          w_iss_last;
  logic          r_iss_act;
  row_t          r_iss_cnt;
  logic [DW-1:0] r_frame [N];

  // Handshakes: a transfer happens on an edge where valid && ready; in_ready
  // depends only on state, out_ready and rst_n, never on in_valid.
  assign w_adv      = !out_valid || out_ready;
  assign w_iss_last = r_iss_act && (r_iss_cnt == LAST_ROW);
  assign in_ready   = rst_n && w_adv && (!r_iss_act || w_iss_last);
  assign w_accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_iss_act <= 1'b0;
      r_iss_cnt <= '0;
    end else if (w_adv) begin
      if (w_accept) begin
        r_iss_act <= 1'b1;
        r_iss_cnt <= '0;
      end else if (r_iss_act) begin
        if (w_iss_last) r_iss_act <= 1'b0;
        r_iss_cnt <= r_iss_cnt + row_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int j = 0; j < N; j++) r_frame[j] <= x_flat[j*DW +: DW];
    end
  end

  logic          r_v    [1:N-1];
  row_t          r_r    [1:N-1];
  logic [OW-1:0] r_p    [1:N-1];
  logic [DW-1:0] r_hold [1:N-1];

  logic          w_in_v [1:N-1];
  row_t          w_in_r [1:N-1];
  logic [OW-1:0] w_in_p [1:N-1];
  logic [DW-1:0] w_x    [1:N-1];
  logic [OW-1:0] w_sum  [1:N-1];

  // A row-0 token takes x_s straight from the frame register and latches it,
  // so later rows of the same frame survive the next frame's acceptance.
  always_comb begin
    w_in_v[1] = r_iss_act;
    w_in_r[1] = r_iss_cnt;
    w_in_p[1] = {{LOG2N{r_frame[0][DW-1]}}, r_frame[0]};
    for (int s = 2; s < N; s++) begin
      w_in_v[s] = r_v[s-1];
      w_in_r[s] = r_r[s-1];
      w_in_p[s] = r_p[s-1];
    end
    for (int s = 1; s < N; s++) begin
      w_x[s]   = (w_in_v[s] && (w_in_r[s] == '0)) ? r_frame[s] : r_hold[s];
      w_sum[s] = (^(row_to_k(w_in_r[s]) & row_t'(s)))
               ? w_in_p[s] - {{LOG2N{w_x[s][DW-1]}}, w_x[s]}
               : w_in_p[s] + {{LOG2N{w_x[s][DW-1]}}, w_x[s]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 1; s < N; s++) begin
        r_v[s]    <= 1'b0;
        r_r[s]    <= '0;
        r_p[s]    <= '0;
        r_hold[s] <= '0;
      end
    end else if (w_adv) begin
      for (int s = 1; s < N; s++) begin
        r_v[s] <= w_in_v[s];
        if (w_in_v[s]) begin
          r_r[s] <= w_in_r[s];
          r_p[s] <= w_sum[s];
          if (w_in_r[s] == '0) r_hold[s] <= r_frame[s];
        end
      end
    end
  end

  assign out_valid = r_v[N-1];
  assign out_data  = r_p[N-1];
  assign out_index = r_r[N-1];
  assign out_last  = (r_r[N-1] == LAST_ROW);

endmodule

// File: tb/tb_systolic_hadamard_npt.sv
// Bench for systolic_hadamard_npt: 4-point natural, 4-point sequency and
// 8-point natural instances checked against a direct-sum reference.
module tb_systolic_hadamard_npt;
  typedef logic [7:0][15:0] p8_t;
  typedef struct packed {
    logic [1:0] d;
    p8_t        x;
    p8_t        y;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              out_ready = 1'b1;
  logic              iv [3];
  logic              ir [3];
  logic              ov [3];
  logic              ol [3];
  logic [35:0]       x4 = '0;
  logic [71:0]       x8 = '0;
  logic signed [10:0] od0, od1;
  logic signed [11:0] od2;
  logic [1:0]        oi0, oi1;
  logic [2:0]        oi2;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit use_model = 1'b0;
  logic [39:0] exp_q [3][$];
  bit   st_v [3];
  int   st_d [3];
  int   st_i [3];
  logic vhist [1024];
  logic irhist [1024];
  vec_t tbl [7];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  systolic_hadamard_npt #(.LOG2N(2), .DW(9), .ORDER(0)) u_nat4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .x_flat(x4),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od0), .out_index(oi0), .out_last(ol[0]));
  systolic_hadamard_npt #(.LOG2N(2), .DW(9), .ORDER(1)) u_seq4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .x_flat(x4),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od1), .out_index(oi1), .out_last(ol[1]));
  systolic_hadamard_npt #(.LOG2N(3), .DW(9), .ORDER(0)) u_nat8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .x_flat(x8),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od2), .out_index(oi2), .out_last(ol[2]));

  task automatic chk(input string name, input int got, input int expv);
    n_vec++;
    if (got != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, expv, $time);
    end
  endtask

  function automatic p8_t pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  function automatic p8_t rnd8();
    p8_t r;
    for (int j = 0; j < 8; j++) r[j] = 16'($urandom_range(0, 511));
    return r;
  endfunction

  // Reference: y_k = sum_j (-1)^popcount(k&j) * x_j, emitted in row order.
  task automatic push_model(input int d, input int l2, input int ord, input logic [71:0] xf);
    int n, k, g;
    int xs [8];
    int y [8];
    n = 1 << l2;
    for (int j = 0; j < n; j++) xs[j] = int'($signed(xf[j*9 +: 9]));
    for (int kk = 0; kk < n; kk++) begin
      y[kk] = 0;
      for (int j = 0; j < n; j++) y[kk] += ($countones(kk & j) % 2 == 1) ? -xs[j] : xs[j];
    end
    for (int r = 0; r < n; r++) begin
      k = r;
      if (ord == 1) begin
        g = r ^ (r >> 1);
        k = 0;
        for (int b = 0; b < l2; b++) if (g[b]) k |= 1 << (l2 - 1 - b);
      end
      exp_q[d].push_back({8'(r), 32'(y[k])});
    end
  endtask

  task automatic mon(input int d, input logic v, input logic rdy, input int data,
                     input int idx, input logic last, input int n);
    logic [39:0] e;
    if (!rst_n) begin
      chk($sformatf("d%0d_in_ready_in_reset", d), int'(rdy), 0);
      exp_q[d].delete();
      st_v[d] = 1'b0;
      return;
    end
    if (st_v[d]) begin
      chk($sformatf("d%0d_stall_valid", d), int'(v), 1);
      chk($sformatf("d%0d_stall_data", d), data, st_d[d]);
      chk($sformatf("d%0d_stall_index", d), idx, st_i[d]);
    end
    st_v[d] = v && !out_ready;
    st_d[d] = data;
    st_i[d] = idx;
    if (v && !out_ready) chk($sformatf("d%0d_in_ready_stall", d), int'(rdy), 0);
    if (v && out_ready) begin
      if (exp_q[d].size() == 0) begin
        chk($sformatf("d%0d_unexpected_row_idx", d), idx, -1);
      end else begin
        e = exp_q[d].pop_front();
        chk($sformatf("d%0d_data_row%0d", d, int'(e[39:32])), data, int'($signed(e[31:0])));
        chk($sformatf("d%0d_index", d), idx, int'(e[39:32]));
        chk($sformatf("d%0d_last", d), int'(last), (int'(e[39:32]) == n - 1) ? 1 : 0);
      end
    end
  endtask

  always @(negedge clk) begin
    vhist[cyc % 1024]  = ov[0];
    irhist[cyc % 1024] = ir[0];
    if (use_model && rst_n) begin
      if (iv[0] && ir[0]) push_model(0, 2, 0, {36'b0, x4});
      if (iv[1] && ir[1]) push_model(1, 2, 1, {36'b0, x4});
      if (iv[2] && ir[2]) push_model(2, 3, 0, x8);
    end
    mon(0, ov[0], ir[0], int'(od0), int'(oi0), ol[0], 4);
    mon(1, ov[1], ir[1], int'(od1), int'(oi1), ol[1], 4);
    mon(2, ov[2], ir[2], int'(od2), int'(oi2), ol[2], 8);
  end

  task automatic send(input int d, input p8_t xs);
    bit ok;
    @(posedge clk); #1;
    for (int j = 0; j < 8; j++) begin
      if (d == 2) x8[j*9 +: 9] = xs[j][8:0];
      else if (j < 4) x4[j*9 +: 9] = xs[j][8:0];
    end
    iv[d] = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (ir[d]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk($sformatf("d%0d_accept_timeout", d), 0, 1);
    @(posedge clk); #1;
    iv[d] = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
    end
    for (int d = 0; d < 3; d++) chk($sformatf("d%0d_rows_left", d), exp_q[d].size(), 0);
  endtask

  initial begin
    int d, n, lat, a1, a2, seen, burst;
    bit ok;
    for (int i = 0; i < 3; i++) iv[i] = 1'b0;

    tbl[0] = '{d: 2'd0, x: pk(1, 2, 3, 4, 0, 0, 0, 0),         y: pk(10, -2, -4, 0, 0, 0, 0, 0)};
    tbl[1] = '{d: 2'd1, x: pk(1, 2, 3, 4, 0, 0, 0, 0),         y: pk(10, -4, 0, -2, 0, 0, 0, 0)};
    tbl[2] = '{d: 2'd2, x: pk(-256, -256, -256, -256, -256, -256, -256, -256),
                        y: pk(-2048, 0, 0, 0, 0, 0, 0, 0)};
    tbl[3] = '{d: 2'd2, x: pk(255, -256, 255, -256, 255, -256, 255, -256),
                        y: pk(-4, 2044, 0, 0, 0, 0, 0, 0)};
    tbl[4] = '{d: 2'd0, x: pk(255, 255, 255, 255, 0, 0, 0, 0), y: pk(1020, 0, 0, 0, 0, 0, 0, 0)};
    tbl[5] = '{d: 2'd1, x: pk(-256, 255, -256, 255, 0, 0, 0, 0), y: pk(-2, 0, 0, -1022, 0, 0, 0, 0)};
    tbl[6] = '{d: 2'd2, x: pk(1, 2, 3, 4, 5, 6, 7, 8),          y: pk(36, -4, -8, 0, -16, 0, 0, 0)};

    // Reset, then reset-state outputs
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", int'(ov[0]), 0);
    chk("rst_out_data", int'(od0), 0);
    chk("rst_out_data8", int'(od2), 0);
    chk("rst_out_index", int'(oi0), 0);
    chk("rst_out_last", int'(ol[0]), 0);
    chk("rst_in_ready", int'(ir[0]), 1);
    chk("rst_in_ready8", int'(ir[2]), 1);

    // Table vectors with known coefficients and latency
    use_model = 1'b0;
    for (int i = 0; i < 7; i++) begin
      d = int'(tbl[i].d);
      n = (d == 2) ? 8 : 4;
      send(d, tbl[i].x);
      for (int r = 0; r < n; r++) exp_q[d].push_back({8'(r), 32'(int'($signed(tbl[i].y[r])))});
      lat = 0;
      while (lat < 20) begin
        @(negedge clk);
        if (ov[d]) break;
        lat++;
      end
      chk($sformatf("vec%0d_latency", i), lat, n - 1);
      drain();
    end

    // Back-to-back frames with in_valid held high
    use_model = 1'b1;
    @(posedge clk); #1;
    x4 = 36'($urandom()) ^ {4'($urandom()), 32'd0};
    iv[0] = 1'b1;
    a1 = 0;
    a2 = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (ir[0]) begin
        a1 = cyc + 1;
        break;
      end
    end
    @(posedge clk); #1;
    x4 = 36'($urandom()) ^ {4'($urandom()), 32'd0};
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (ir[0]) begin
        a2 = cyc + 1;
        break;
      end
    end
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (14) @(negedge clk);
    chk("b2b_accept_spacing", a2 - a1, 4);
    for (int m = 3; m <= 10; m++) chk($sformatf("b2b_valid_e%0d", m), int'(vhist[(a1 + m) % 1024]), 1);
    chk("b2b_valid_after", int'(vhist[(a1 + 11) % 1024]), 0);
    for (int m = 0; m <= 2; m++) chk($sformatf("b2b_in_ready_row%0d", m), int'(irhist[(a1 + m) % 1024]), 0);
    chk("b2b_in_ready_row3", int'(irhist[(a1 + 3) % 1024]), 1);
    drain();

    // Random frames on all instances with out_ready stall bursts
    burst = 0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) iv[i] = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < 4; j++) x4[j*9 +: 9] = 9'($urandom_range(0, 511));
      for (int j = 0; j < 8; j++) x8[j*9 +: 9] = 9'($urandom_range(0, 511));
      if (burst > 0) begin
        out_ready = 1'b0;
        burst--;
      end else begin
        out_ready = 1'b1;
        if ($urandom_range(0, 7) == 0) burst = $urandom_range(1, 6);
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) iv[i] = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset one edge after row 1 of a frame
    send(0, rnd8());
    ok = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (ov[0] && oi0 == 2'd1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rstmid_row1_seen", int'(ok), 1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_out_valid", int'(ov[0]), 0);
    chk("rstmid_out_data", int'(od0), 0);
    seen = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (ov[0]) seen++;
    end
    chk("rstmid_rows_after", seen, 0);
    send(0, rnd8());
    send(2, rnd8());
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d expected 0", 1);
    $fatal(1, "timeout");
  end
endmodule
